// File: rtl/lane_mask_sequencer.sv
// Accumulates a sticky lane-enable mask per group under a term budget and hands it off over valid/ready.
// Optional drop statistics output is enabled by defining LANE_MASK_STATS_EN.
module lane_mask_sequencer #(
    parameter int LANES     = 32,
    parameter int SEL_W     = 5,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_mask,
    output logic [CNT_W-1:0] out_count,
`ifdef LANE_MASK_STATS_EN
    output logic [15:0]      drop_count,
`endif
    output logic             out_sat
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [LANES-1:0]   mask_reg, mask_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               sat_reg, sat_next;
    logic [LANES-1:0]   sel_onehot;
    logic               sel_in_range;
    logic               sel_dup;
    logic               budget_left;
    logic               accept;

    // An out-of-range index decodes to all zeros, which doubles as the range check.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_decode
            assign sel_onehot[gi] = (in_sel == SEL_W'(gi));
        end
    endgenerate

    assign sel_in_range = |sel_onehot;
    assign sel_dup      = |(sel_onehot & mask_reg);
    assign budget_left  = (count_reg < CNT_W'(MAX_TERMS));
    assign accept       = in_valid && (state_reg == ACCUM);

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        count_next = count_reg;
        sat_next   = sat_reg;
        if (clear) begin
            state_next = ACCUM;
            mask_next  = '0;
            count_next = '0;
            sat_next   = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (sel_in_range && !sel_dup) begin
                            if (budget_left) begin
                                mask_next  = mask_reg | sel_onehot;
                                count_next = count_reg + CNT_W'(1);
                            end else begin
                                sat_next = 1'b1;
                            end
                        end
                        if (in_last) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                        mask_next  = '0;
                        count_next = '0;
                        sat_next   = 1'b0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
            mask_reg  <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            count_reg <= count_next;
            sat_reg   <= sat_next;
        end
    end

`ifdef LANE_MASK_STATS_EN
    logic [15:0] drop_reg, drop_next;
    logic        drop_event;

    // A drop is an accepted, non-cleared beat that is out of range or blocked by the budget.
    assign drop_event = accept && !clear &&
                        (!sel_in_range || (!sel_dup && !budget_left));

    always_comb begin
        drop_next = drop_reg;
        if (drop_event && (drop_reg != 16'hFFFF)) begin
            drop_next = drop_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_reg <= '0;
        end else begin
            drop_reg <= drop_next;
        end
    end

    assign drop_count = drop_reg;
`endif

    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == HOLD);
    assign out_mask  = mask_reg;
    assign out_count = count_reg;
    assign out_sat   = sat_reg;

endmodule

// File: tb/tb_lane_mask_sequencer.sv
// Directed self-checking bench for lane_mask_sequencer; drop_count checks are active with LANE_MASK_STATS_EN.
module tb_lane_mask_sequencer;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mask;
    logic [5:0]  out_count;
    logic        out_sat;
`ifdef LANE_MASK_STATS_EN
    logic [15:0] drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    lane_mask_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_count  (out_count),
`ifdef LANE_MASK_STATS_EN
        .drop_count (drop_count),
`endif
        .out_sat    (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] sel, input logic last);
        in_valid = 1'b1;
        in_sel   = sel;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("beat sel=%0d last=%0b -> mask=%h count=%0d sat=%0b valid=%0b",
                 sel, last, out_mask, out_count, out_sat, out_valid);
    endtask

    task automatic check_out(input string tag, input logic [31:0] m, input logic [31:0] c,
                             input logic [31:0] s, input logic [31:0] v);
        check({tag, "_mask"},  out_mask, m);
        check({tag, "_count"}, {26'd0, out_count}, c);
        check({tag, "_sat"},   {31'd0, out_sat}, s);
        check({tag, "_valid"}, {31'd0, out_valid}, v);
        check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, ~v[0]});
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_out(tag, 32'h0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sel = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_out("reset", 32'h0, 0, 0, 0);
`ifdef LANE_MASK_STATS_EN
        check("reset_drop", {16'd0, drop_count}, 0);
`endif

        // 1. single group
        send(5'd3, 1'b0);
        send(5'd7, 1'b0);
        check("t1_notyet_valid", {31'd0, out_valid}, 0);
        send(5'd31, 1'b1);
        check_out("t1", 32'h8000_0088, 3, 0, 1);
        consume("t1_consume");

        // out_ready during ACCUM has no effect
        send(5'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_out("accum_ready", 32'h2, 1, 0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_out("clear_idle", 32'h0, 0, 0, 0);

        // 2. duplicates
        send(5'd5, 1'b0);
        send(5'd5, 1'b0);
        send(5'd5, 1'b1);
        check_out("t2", 32'h20, 1, 0, 1);
`ifdef LANE_MASK_STATS_EN
        check("t2_drop", {16'd0, drop_count}, 0);
`endif
        consume("t2_consume");

        // 3. budget: lanes 0..9, only first 8 fit
        for (int i = 0; i < 9; i++) send(5'(i), 1'b0);
        check_out("t3_mid", 32'hFF, 8, 1, 0);
        send(5'd9, 1'b1);
        check_out("t3", 32'hFF, 8, 1, 1);
`ifdef LANE_MASK_STATS_EN
        check("t3_drop", {16'd0, drop_count}, 2);
`endif

        // 4. backpressure in HOLD, with a stray input beat that must not be taken
        in_valid = 1'b1; in_sel = 5'd20; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("hold cycle %0d: mask=%h count=%0d valid=%0b", i, out_mask, out_count, out_valid);
            check_out("t4_hold", 32'hFF, 8, 1, 1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume("t4_release");
`ifdef LANE_MASK_STATS_EN
        check("t4_drop", {16'd0, drop_count}, 2);
`endif

        // 5. clear mid-group discards the concurrent beat
        send(5'd2, 1'b0);
        send(5'd4, 1'b0);
        check_out("t5_pre", 32'h14, 2, 0, 0);
        clear = 1'b1; in_valid = 1'b1; in_sel = 5'd6; in_last = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_out("t5_clear", 32'h0, 0, 0, 0);
        send(5'd1, 1'b1);
        check_out("t5_next", 32'h2, 1, 0, 1);

        // clear wins over a same-cycle out handshake
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        check_out("clear_hold", 32'h0, 0, 0, 0);

        // 6. reset while HOLD
        send(5'd9, 1'b0);
        send(5'd30, 1'b1);
        check_out("t6_pre", 32'h4000_0200, 2, 0, 1);
        reset = 1'b1;
        tick();
        check_out("t6_reset", 32'h0, 0, 0, 0);
`ifdef LANE_MASK_STATS_EN
        check("t6_drop", {16'd0, drop_count}, 0);
`endif
        reset = 1'b0;
        tick();
        check_out("t6_after", 32'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
